// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: instruction-memory read bus (address out, word back same cycle)
//   imem_addr  : byte address from the fetch unit (word = addr[ADDR_W-1:2])
//   imem_instr : instruction word returned combinationally by imem
interface inst_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  modport master (output imem_addr, input imem_instr);
  modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage owning the PC and the IF/ID pipeline register
//   clk, rst_n       : clock, async active-low reset
//   imem             : instruction-memory bus (master side)
//   stall_i          : hold PC and IF/ID
//   redirect_i       : taken branch/jump, flush IF/ID and jump to redirect_pc_i
//   redirect_pc_i    : redirect target (low two bits ignored)
//   if_id_*_o        : registered valid, instruction, PC and PC+4
//   halted_o         : fetch stopped after running past LAST_PC
module inst_fetch_unit #(
  parameter int                  ADDR_W   = 8,
  parameter int                  INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = 8'h00,
  parameter logic [ADDR_W-1:0]   LAST_PC  = 8'h4C,
  parameter logic [INSTR_W-1:0]  NOP      = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst_n,
  inst_fetch_unit_if.master   imem,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  output logic                if_id_valid_o,
  output logic [INSTR_W-1:0]  if_id_instr_o,
  output logic [ADDR_W-1:0]   if_id_pc_o,
  output logic [ADDR_W-1:0]   if_id_pc4_o,
  output logic                halted_o
);
  typedef enum logic {RUN, HALT} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, if_pc_q, if_pc_d, if_pc4_q, if_pc4_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   tgt, pc4;
  logic                run, adv, to_halt, bubble;
  // masking rather than slicing keeps every bit of the target port in use
  assign tgt     = redirect_pc_i & ~ADDR_W'(3);
  assign pc4     = pc_q + ADDR_W'(4);
  assign run     = state_q == RUN;
  // running off the end of the program wins over a stall
  assign to_halt = run && !redirect_i && pc_q > LAST_PC;
  assign adv     = run && !redirect_i && !stall_i && !to_halt;
  assign bubble  = redirect_i || to_halt;
  always_comb begin
    state_d  = redirect_i ? ((!run && tgt > LAST_PC) ? HALT : RUN) : to_halt ? HALT : state_q;
    pc_d     = redirect_i ? tgt : adv ? pc4 : pc_q;
    valid_d  = adv ? 1'b1 : bubble ? 1'b0 : valid_q;
    instr_d  = adv ? imem.imem_instr : bubble ? NOP : instr_q;
    if_pc_d  = adv ? pc_q : if_pc_q;
    if_pc4_d = adv ? pc4 : if_pc4_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= NOP;
      if_pc_q  <= '0;
      if_pc4_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      if_pc_q  <= if_pc_d;
      if_pc4_q <= if_pc4_d;
    end
  end
  assign imem.imem_addr = pc_q;
  assign if_id_valid_o  = valid_q;
  assign if_id_instr_o  = instr_q;
  assign if_id_pc_o     = if_pc_q;
  assign if_id_pc4_o    = if_pc4_q;
  assign halted_o       = state_q == HALT;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized + directed bench with a behavioural fetch model
module tb_inst_fetch_unit;
  localparam logic [7:0]  LAST = 8'h4C;
  localparam logic [31:0] NOP  = 32'h00000013;
  logic        clk = 0;
  logic        rst_n;
  logic        stall = 0, redirect = 0;
  logic [7:0]  rpc = 0;
  logic        v, h;
  logic [31:0] ins;
  logic [7:0]  ipc, ipc4;
  logic [31:0] imem [64];
  int          tests = 0, fails = 0;
  inst_fetch_unit_if bus();
  assign bus.imem_instr = imem[bus.imem_addr[7:2]];
  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem(bus.master),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(rpc),
    .if_id_valid_o(v), .if_id_instr_o(ins), .if_id_pc_o(ipc),
    .if_id_pc4_o(ipc4), .halted_o(h)
  );
  always #5 clk = ~clk;
  // model: program counter, halt flag and the contents of the IF/ID register
  logic [7:0]  m_pc = 0, m_ipc = 0, m_ipc4 = 0;
  logic        m_halt = 0, m_v = 0;
  logic [31:0] m_ins = NOP;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_halt = 0; m_v = 0; m_ins = NOP; m_ipc = 0; m_ipc4 = 0;
    end else if (redirect) begin
      m_pc = rpc & 8'hFC; m_v = 0; m_ins = NOP;
      if (m_halt) m_halt = (m_pc > LAST);
    end else if (!m_halt) begin
      if (m_pc > LAST) begin
        m_halt = 1; m_v = 0; m_ins = NOP;
      end else if (!stall) begin
        m_v = 1; m_ins = imem[m_pc / 4]; m_ipc = m_pc; m_ipc4 = m_pc + 8'd4; m_pc = m_pc + 8'd4;
      end
    end
  end
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    chk("m_valid", 32'(v), 32'(m_v));
    chk("m_instr", ins, m_ins);
    chk("m_halted", 32'(h), 32'(m_halt));
    chk("m_addr", 32'(bus.imem_addr), 32'(m_pc));
    if (m_v) begin
      chk("m_pc", 32'(ipc), 32'(m_ipc));
      chk("m_pc4", 32'(ipc4), 32'(m_ipc4));
    end
  end
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[1] = 32'h00100093; imem[2] = 32'h00200113;
    imem[3] = 32'h00308193; imem[17] = 32'h4d244893;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(v), 0);
    chk("rst_instr", ins, NOP);
    chk("rst_pc", 32'(ipc), 0);
    chk("rst_pc4", 32'(ipc4), 0);
    chk("rst_halt", 32'(h), 0);
    chk("rst_addr", 32'(bus.imem_addr), 0);
    rst_n = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("seq_pc", 32'(ipc), 32'((k - 1) * 4));
      chk("seq_instr", ins, imem[k - 1]);
      if (k == 2) begin
        chk("edge2_instr", ins, 32'h00100093);
        chk("edge2_pc4", 32'(ipc4), 32'h08);
      end
    end
    chk("last_pc", 32'(ipc), 32'h4C);
    chk("last_valid", 32'(v), 1);
    step();
    chk("halt_flag", 32'(h), 1);
    chk("halt_valid", 32'(v), 0);
    chk("halt_instr", ins, NOP);
    repeat (5) begin
      step();
      chk("halt_addr", 32'(bus.imem_addr), 32'h50);
    end
    redirect = 1; rpc = 8'h44;
    step();
    redirect = 0;
    chk("hr_halt", 32'(h), 0);
    chk("hr_addr", 32'(bus.imem_addr), 32'h44);
    chk("hr_bubble", 32'(v), 0);
    step();
    chk("hr_instr", ins, 32'h4d244893);
    chk("hr_valid", 32'(v), 1);
    repeat (3) step();
    chk("rehalt", 32'(h), 1);
    redirect = 1; rpc = 8'h60;
    step();
    redirect = 0;
    chk("hr60_halt", 32'(h), 1);
    chk("hr60_addr", 32'(bus.imem_addr), 32'h60);
    redirect = 1; rpc = 8'h00;
    step();
    redirect = 0;
    repeat (3) step();
    stall = 1;
    repeat (3) begin
      step();
      chk("stall_addr", 32'(bus.imem_addr), 32'h0C);
      chk("stall_pc", 32'(ipc), 32'h08);
    end
    stall = 0;
    step();
    chk("resume_pc", 32'(ipc), 32'h0C);
    chk("resume_instr", ins, 32'h00308193);
    repeat (4) step();
    chk("pre_rd_addr", 32'(bus.imem_addr), 32'h20);
    redirect = 1; stall = 1; rpc = 8'h09;
    step();
    redirect = 0; stall = 0;
    chk("rd_addr", 32'(bus.imem_addr), 32'h08);
    chk("rd_valid", 32'(v), 0);
    step();
    chk("rd_pc", 32'(ipc), 32'h08);
    chk("rd_instr", ins, 32'h00200113);
    repeat (600) begin
      stall = ($urandom % 10) < 3;
      redirect = ($urandom % 10) == 0;
      rpc = ($urandom % 2) ? 8'($urandom % 8'h50) : 8'($urandom);
      step();
    end
    redirect = 1; stall = 0; rpc = 8'h30;
    step();
    redirect = 0; stall = 1;
    step();
    chk("pre_rst_addr", 32'(bus.imem_addr), 32'h30);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_addr", 32'(bus.imem_addr), 0);
    chk("arst_valid", 32'(v), 0);
    chk("arst_instr", ins, NOP);
    chk("arst_halt", 32'(h), 0);
    chk("arst_pc", 32'(ipc), 0);
    @(negedge clk);
    rst_n = 1; stall = 0;
    repeat (40) begin
      stall = ($urandom % 10) < 2;
      redirect = ($urandom % 12) == 0;
      rpc = 8'($urandom);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
